// File: rtl/rca_4bit_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_4bit_pkg;

    // Default operand/sum width of the adder.
    localparam int unsigned RCA_WIDTH = 4;

endpackage : rca_4bit_pkg

// File: rtl/rca_4bit_full_adder.sv
// Single-bit full adder: one ripple stage of rca_4bit.
module rca_4bit_full_adder
    import rca_4bit_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    logic w_prop;

    // Propagate term, sum bit and carry-out of this stage.
    always_comb begin
        w_prop = i_a ^ i_b;
        o_s    = w_prop ^ i_ci;
        o_co   = (i_a & i_b) | (i_ci & w_prop);
    end

endmodule : rca_4bit_full_adder

// File: rtl/rca_4bit.sv
// WIDTH-bit ripple-carry adder with carry-out, signed overflow and a
// registered copy of the results for synchronous consumers.
module rca_4bit
    import rca_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = RCA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_carry[0] = cin;

    for (genvar g_i = 0; g_i < WIDTH; g_i++) begin : g_stage
        rca_4bit_full_adder u_fa (
            .i_a  (a[g_i]),
            .i_b  (b[g_i]),
            .i_ci (w_carry[g_i]),
            .o_s  (w_sum[g_i]),
            .o_co (w_carry[g_i+1])
        );
    end

    // Combinational results; overflow compares carry into and out of the MSB.
    always_comb begin
        sum  = w_sum;
        cout = w_carry[WIDTH];
        ovf  = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end

    // Output register stage: capture results each edge, clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
            r_ovf  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
        end
    end

    assign sum_q  = r_sum;
    assign cout_q = r_cout;
    assign ovf_q  = r_ovf;

endmodule : rca_4bit

// File: tb/tb_rca_4bit.sv
// Directed and exhaustive self-checking bench for rca_4bit (WIDTH = 4).
module tb_rca_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    int n_tests;
    int n_fail;

    rca_4bit #(
        .WIDTH (4)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one vector mid-cycle, check combinational outputs, then the registered copy.
    task automatic directed(input string tag, input logic [3:0] va, input logic [3:0] vb,
                            input logic vc, input logic [3:0] es, input logic ec,
                            input logic eo);
        @(negedge clk);
        a   = va;
        b   = vb;
        cin = vc;
        #1;
        check({tag, ".sum"}, 32'(sum), 32'(es));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
        check({tag, ".sum_q"}, 32'(sum_q), 32'(es));
        check({tag, ".cout_q"}, 32'(cout_q), 32'(ec));
        check({tag, ".ovf_q"}, 32'(ovf_q), 32'(eo));
    endtask

    initial begin
        logic [8:0] vec;
        int         ref_u;
        int         ref_s;
        int         sa;
        int         sb;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        a       = 4'b0000;
        b       = 4'b0000;
        cin     = 1'b0;

        // Reset state and combinational path valid while in reset.
        #12;
        check("rst.sum_q", 32'(sum_q), 32'h0);
        check("rst.cout_q", 32'(cout_q), 32'h0);
        check("rst.ovf_q", 32'(ovf_q), 32'h0);
        a = 4'b0101;
        b = 4'b0011;
        cin = 1'b1;
        #1;
        check("rst.comb_sum", 32'(sum), 32'h9);
        check("rst.comb_ovf", 32'(ovf), 32'h1);
        @(posedge clk);
        #1;
        check("rst.hold_sum_q", 32'(sum_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        directed("1p2", 4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0);
        directed("5p3c", 4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1);
        directed("fp1", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        directed("ap5c", 4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);
        directed("8p8", 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        directed("fpfc", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

        // Registers hold all-ones result; async reset must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async.sum_q", 32'(sum_q), 32'h0);
        check("async.cout_q", 32'(cout_q), 32'h0);
        check("async.comb_sum", 32'(sum), 32'hf);
        @(negedge clk);
        a = 4'b0101;
        b = 4'b0011;
        cin = 1'b1;
        rst_n = 1'b1;
        #1;
        check("release.pre_edge", 32'(ovf_q), 32'h0);
        @(posedge clk);
        #1;
        check("release.sum_q", 32'(sum_q), 32'h9);
        check("release.ovf_q", 32'(ovf_q), 32'h1);

        // Exhaustive sweep of the combinational path against integer references.
        for (int i = 0; i < 512; i++) begin
            vec = 9'(i);
            cin = vec[8];
            a   = vec[7:4];
            b   = vec[3:0];
            #1;
            ref_u = int'(vec[7:4]) + int'(vec[3:0]) + int'(vec[8]);
            sa = vec[7] ? int'(vec[7:4]) - 16 : int'(vec[7:4]);
            sb = vec[3] ? int'(vec[3:0]) - 16 : int'(vec[3:0]);
            ref_s = sa + sb + int'(vec[8]);
            check("sweep.result", 32'({cout, sum}), 32'(ref_u));
            check("sweep.ovf", 32'(ovf), ((ref_s > 7) || (ref_s < -8)) ? 32'h1 : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rca_4bit
